// File: rtl/wave_gen_pkg.sv
// +----------------------------------------------------------------------+
// | wave_gen_pkg : shared DAC frame constants and SPI FSM state encoding  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package wave_gen_pkg;

   localparam int unsigned c_frame_w   = 24;
   localparam logic [7:0]  c_dac_cmd   = 8'h3F;
   localparam logic [4:0]  c_last_bit  = 5'd23;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_CS_HOLD  = 3'd3,
      ST_CS_GAP   = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// +----------------------------------------------------------------------+
// | spi_tick_gen : half-period timer with terminal-count pulse            |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_tick_gen #(
   parameter int unsigned HALF_DIV = 2
) (
   input  logic clk_tx,
   input  logic rst_clk_tx,
   input  logic i_en,
   output logic o_tick,
   output logic o_pre_tick
);

   localparam logic [7:0] c_tc      = 8'(HALF_DIV - 1);
   localparam logic       c_has_pre = (HALF_DIV >= 2);
   localparam logic [7:0] c_pre_tc  = c_has_pre ? 8'(HALF_DIV - 2) : 8'd0;

   logic [7:0] r_cnt;

   // Held at zero while disabled so every phase starts from a clean count.
   always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
      if (rst_clk_tx) begin
         r_cnt <= 8'd0;
      end else if (!i_en || (r_cnt == c_tc)) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_tick     = i_en && (r_cnt == c_tc);
   assign o_pre_tick = c_has_pre && i_en && (r_cnt == c_pre_tc);

endmodule

`default_nettype wire

// File: rtl/dac_spi.sv
// +----------------------------------------------------------------------+
// | dac_spi  : serialises {DAC_CMD, sample} as a 24-bit SPI mode-0 frame  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dac_spi
   import wave_gen_pkg::*;
#(
   parameter int unsigned SPI_HALF_DIV = 2,
   parameter logic [7:0]  DAC_CMD      = c_dac_cmd
) (
   input  logic        clk_tx,
   input  logic        rst_clk_tx,
   input  logic        samp_val,
   input  logic [15:0] samp,
   output logic        samp_rdy,
   output logic        spi_clk_o,
   output logic        spi_mosi_o,
   output logic        dac_cs_n_o,
   output logic        frame_done
);

   state_t                 r_state, w_state;
   logic [4:0]             r_bit_cnt, w_bit_cnt;
   logic [c_frame_w-1:0]   r_shreg, w_shreg;
   logic                   r_cs_n, w_cs_n;
   logic                   r_sclk, w_sclk;
   logic                   r_rdy, w_rdy;
   logic                   r_done, w_done;
   logic                   w_tick, w_pre_tick;

   spi_tick_gen #(
      .HALF_DIV (SPI_HALF_DIV)
   ) u_tick (
      .clk_tx     (clk_tx),
      .rst_clk_tx (rst_clk_tx),
      .i_en       (r_state != ST_IDLE),
      .o_tick     (w_tick),
      .o_pre_tick (w_pre_tick)
   );

   always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
      if (rst_clk_tx) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 5'd0;
         r_shreg   <= '0;
         r_cs_n    <= 1'b1;
         r_sclk    <= 1'b0;
         r_rdy     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_bit_cnt <= w_bit_cnt;
         r_shreg   <= w_shreg;
         r_cs_n    <= w_cs_n;
         r_sclk    <= w_sclk;
         r_rdy     <= w_rdy;
         r_done    <= w_done;
      end
   end

   // spi_clk_o itself marks the low/high phase of the current bit.
   always_comb begin
      w_state   = r_state;
      w_bit_cnt = r_bit_cnt;
      w_shreg   = r_shreg;
      w_cs_n    = r_cs_n;
      w_sclk    = r_sclk;
      w_rdy     = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (samp_val && r_rdy) begin
               w_state   = ST_CS_SETUP;
               w_shreg   = {DAC_CMD, samp};
               w_bit_cnt = 5'd0;
               w_cs_n    = 1'b0;
               w_sclk    = 1'b0;
            end else begin
               w_rdy  = 1'b1;
               w_cs_n = 1'b1;
               w_sclk = 1'b0;
            end
         end
         ST_CS_SETUP: begin
            if (w_tick) begin
               w_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_tick) begin
               if (!r_sclk) begin
                  w_sclk = 1'b1;
               end else if (r_bit_cnt == c_last_bit) begin
                  w_sclk  = 1'b0;
                  w_state = ST_CS_HOLD;
               end else begin
                  // Data advances only on the falling edge of spi_clk_o.
                  w_sclk    = 1'b0;
                  w_bit_cnt = r_bit_cnt + 5'd1;
                  w_shreg   = {r_shreg[c_frame_w-2:0], 1'b0};
               end
            end
         end
         ST_CS_HOLD: begin
            if (w_tick) begin
               w_state = ST_CS_GAP;
               w_cs_n  = 1'b1;
               w_shreg = '0;
               w_done  = (SPI_HALF_DIV == 1);
            end
         end
         ST_CS_GAP: begin
            // Registered pulse lands on the final gap cycle.
            w_done = w_pre_tick;
            if (w_tick) begin
               w_state = ST_IDLE;
               w_rdy   = 1'b1;
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_cs_n  = 1'b1;
            w_sclk  = 1'b0;
         end
      endcase
   end

   assign samp_rdy   = r_rdy;
   assign spi_clk_o  = r_sclk;
   assign spi_mosi_o = r_shreg[c_frame_w-1];
   assign dac_cs_n_o = r_cs_n;
   assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi.sv
// +----------------------------------------------------------------------+
// | tb_dac_spi : directed self-checking bench for dac_spi (DIV=2, DIV=1)  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dac_spi;

   logic        clk;
   logic        rst;
   logic [15:0] samp;
   logic        val_a, val_b;
   logic        rdy_a, sclk_a, mosi_a, csn_a, done_a;
   logic        rdy_b, sclk_b, mosi_b, csn_b, done_b;
   logic        sel;
   logic        w_sclk, w_mosi, w_csn, w_rdy, w_done;

   int          checks, errors, ecnt, t0;
   logic [23:0] m_bits;
   int          m_rises, m_low, m_hi, m_done_at, m_done_cnt, m_rdy_at, m_r1, m_r2;
   logic        m_ok;

   dac_spi #(.SPI_HALF_DIV(2)) u_dut_a (
      .clk_tx(clk), .rst_clk_tx(rst), .samp_val(val_a), .samp(samp),
      .samp_rdy(rdy_a), .spi_clk_o(sclk_a), .spi_mosi_o(mosi_a),
      .dac_cs_n_o(csn_a), .frame_done(done_a)
   );

   dac_spi #(.SPI_HALF_DIV(1)) u_dut_b (
      .clk_tx(clk), .rst_clk_tx(rst), .samp_val(val_b), .samp(samp),
      .samp_rdy(rdy_b), .spi_clk_o(sclk_b), .spi_mosi_o(mosi_b),
      .dac_cs_n_o(csn_b), .frame_done(done_b)
   );

   assign w_sclk = sel ? sclk_b : sclk_a;
   assign w_mosi = sel ? mosi_b : mosi_a;
   assign w_csn  = sel ? csn_b  : csn_a;
   assign w_rdy  = sel ? rdy_b  : rdy_a;
   assign w_done = sel ? done_b : done_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Follows the selected DUT from the current cycle until samp_rdy returns.
   task automatic watch(input int budget);
      logic prev;
      prev       = 1'b0;
      m_bits     = '0;
      m_rises    = 0;
      m_low      = 0;
      m_hi       = 0;
      m_done_at  = -1;
      m_done_cnt = 0;
      m_rdy_at   = -1;
      m_r1       = 0;
      m_r2       = 0;
      m_ok       = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (w_sclk && !prev) begin
            m_bits = {m_bits[22:0], w_mosi};
            m_rises++;
            if (m_rises == 1) m_r1 = ecnt;
            if (m_rises == 2) m_r2 = ecnt;
         end
         prev = w_sclk;
         if (!w_csn) m_low++;
         else if (!w_rdy) m_hi++;
         if (w_done) begin
            m_done_cnt++;
            m_done_at = ecnt;
         end
         if (w_rdy) begin
            m_ok     = 1'b1;
            m_rdy_at = ecnt;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int   r;
      int   dn;
      logic p;
      checks = 0;
      errors = 0;
      ecnt   = 0;
      rst    = 1'b1;
      samp   = 16'h0000;
      val_a  = 1'b0;
      val_b  = 1'b0;
      sel    = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_cs_n",  32'(csn_a),  32'd1);
      chk("rst_sclk",  32'(sclk_a), 32'd0);
      chk("rst_mosi",  32'(mosi_a), 32'd0);
      chk("rst_rdy",   32'(rdy_a),  32'd0);
      chk("rst_done",  32'(done_a), 32'd0);
      rst = 1'b0;
      tick();
      chk("rdy_after_rst", 32'(rdy_a), 32'd1);

      // Single frame, DIV=2
      samp  = 16'hA5C3;
      val_a = 1'b1;
      tick();
      t0    = ecnt;
      val_a = 1'b0;
      chk("rdy_low_after_xfer", 32'(rdy_a), 32'd0);
      watch(200);
      chk("f1_end",       32'(m_ok),             32'd1);
      chk("f1_bits",      32'(m_bits),           32'h3FA5C3);
      chk("f1_rises",     32'(m_rises),          32'd24);
      chk("f1_cs_low",    32'(m_low),            32'd100);
      chk("f1_done_cnt",  32'(m_done_cnt),       32'd1);
      chk("f1_done_at",   32'(m_done_at - t0),   32'd101);
      chk("f1_rdy_at",    32'(m_rdy_at - t0),    32'd102);
      chk("f1_sclk_per",  32'(m_r2 - m_r1),      32'd4);

      // Back-to-back with samp_val held high
      samp  = 16'h0000;
      val_a = 1'b1;
      tick();
      t0   = ecnt;
      samp = 16'hFFFF;
      watch(200);
      chk("b2b1_bits",   32'(m_bits),          32'h3F0000);
      chk("b2b1_gap",    32'(m_hi),            32'd2);
      chk("b2b1_rdy_at", 32'(m_rdy_at - t0),   32'd102);
      tick();
      chk("b2b_no_extra_idle", 32'(rdy_a), 32'd0);
      chk("b2b_cs_low",        32'(csn_a), 32'd0);
      val_a = 1'b0;
      watch(200);
      chk("b2b2_bits",  32'(m_bits),  32'h3FFFFF);
      chk("b2b2_rises", 32'(m_rises), 32'd24);

      // samp_val toggled and then held while busy
      samp  = 16'h1234;
      val_a = 1'b1;
      tick();
      t0   = ecnt;
      samp = 16'h0F0F;
      tick();
      tick();
      val_a = 1'b0;
      tick();
      val_a = 1'b1;
      samp  = 16'hBEEF;
      watch(200);
      chk("busy_bits",   32'(m_bits),        32'h3F1234);
      chk("busy_rdy_at", 32'(m_rdy_at - t0), 32'd102);
      tick();
      chk("busy_accept", 32'(rdy_a), 32'd0);
      val_a = 1'b0;
      watch(200);
      chk("held_bits", 32'(m_bits), 32'h3FBEEF);

      // Reset after the 10th rising edge
      samp  = 16'h1111;
      val_a = 1'b1;
      tick();
      val_a = 1'b0;
      r     = 0;
      dn    = 0;
      p     = sclk_a;
      for (int i = 0; i < 200 && r < 10; i++) begin
         tick();
         if (sclk_a && !p) r++;
         p = sclk_a;
         if (done_a) dn++;
      end
      chk("mid_rises", 32'(r), 32'd10);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_cs_n", 32'(csn_a),  32'd1);
      chk("mid_rst_sclk", 32'(sclk_a), 32'd0);
      chk("mid_rst_rdy",  32'(rdy_a),  32'd0);
      tick();
      if (done_a) dn++;
      tick();
      if (done_a) dn++;
      chk("mid_no_done", 32'(dn), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_rdy", 32'(rdy_a), 32'd1);
      samp  = 16'h2468;
      val_a = 1'b1;
      tick();
      val_a = 1'b0;
      watch(200);
      chk("post_rst_bits",  32'(m_bits),     32'h3F2468);
      chk("post_rst_rises", 32'(m_rises),    32'd24);
      chk("post_rst_done",  32'(m_done_cnt), 32'd1);

      // DIV=1 instance
      sel = 1'b1;
      chk("d1_idle_rdy", 32'(rdy_b), 32'd1);
      samp  = 16'h8001;
      val_b = 1'b1;
      tick();
      t0    = ecnt;
      val_b = 1'b0;
      watch(100);
      chk("d1_bits",     32'(m_bits),        32'h3F8001);
      chk("d1_rises",    32'(m_rises),       32'd24);
      chk("d1_cs_low",   32'(m_low),         32'd50);
      chk("d1_done_at",  32'(m_done_at - t0), 32'd50);
      chk("d1_rdy_at",   32'(m_rdy_at - t0), 32'd51);
      chk("d1_sclk_per", 32'(m_r2 - m_r1),   32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
